// File: rtl/context_switch_engine.sv
// Context-switch sequencer: saves registers 1..31 of the process set into a
// per-process data-memory area, or restores them from it through the bank write port.
module context_switch_engine #(
    parameter int CTX_BASE   = 0,
    parameter int CTX_WORDS  = 32,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  mode,
    input  logic [3:0]            indiceProcesso,
    output logic [4:0]            regReadAddr,
    input  logic [31:0]           regReadData,
    output logic [4:0]            regWriteAddr,
    output logic [31:0]           regWriteData,
    output logic                  regWrite,
    output logic [ADDR_WIDTH-1:0] memAddr,
    output logic                  memWrite,
    output logic [31:0]           memWriteData,
    input  logic [31:0]           memReadData,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SAVE,
        S_RESTORE,
        S_DONE
    } state_t;

    state_t                state_q, state_d;
    logic [4:0]            cnt_q, cnt_d;
    logic [4:0]            cnt_inc;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [ADDR_WIDTH-1:0] start_base;
    logic [4:0]            reg_read_addr_q, reg_read_addr_d;
    logic [4:0]            reg_write_addr_q, reg_write_addr_d;
    logic                  reg_write_q, reg_write_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic                  mem_write_q, mem_write_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    // Address arithmetic wraps silently at ADDR_WIDTH bits.
    function automatic logic [ADDR_WIDTH-1:0] ctx_word(input logic [ADDR_WIDTH-1:0] b,
                                                       input logic [5:0] off);
        return b + ADDR_WIDTH'(off);
    endfunction

    assign start_base = ADDR_WIDTH'(CTX_BASE)
                      + ADDR_WIDTH'(indiceProcesso) * ADDR_WIDTH'(CTX_WORDS);
    assign cnt_inc    = cnt_q + 5'd1;

    always_comb begin
        state_d          = state_q;
        cnt_d            = cnt_q;
        base_d           = base_q;
        reg_read_addr_d  = '0;
        reg_write_addr_d = '0;
        reg_write_d      = 1'b0;
        mem_addr_d       = '0;
        mem_write_d      = 1'b0;
        busy_d           = 1'b0;
        done_d           = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    base_d     = start_base;
                    busy_d     = 1'b1;
                    mem_addr_d = ctx_word(start_base, 6'd1);
                    if (mode) begin
                        state_d = S_RESTORE;
                        cnt_d   = 5'd0;
                    end else begin
                        state_d         = S_SAVE;
                        cnt_d           = 5'd1;
                        reg_read_addr_d = 5'd1;
                        mem_write_d     = 1'b1;
                    end
                end
            end

            S_SAVE: begin
                if (cnt_q == 5'd31) begin
                    state_d = S_DONE;
                    cnt_d   = 5'd0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d           = cnt_inc;
                    busy_d          = 1'b1;
                    mem_write_d     = 1'b1;
                    reg_read_addr_d = cnt_inc;
                    mem_addr_d      = ctx_word(base_q, {1'b0, cnt_inc});
                end
            end

            // Memory read runs one word ahead of the register write it feeds.
            S_RESTORE: begin
                if (cnt_q == 5'd31) begin
                    state_d = S_DONE;
                    cnt_d   = 5'd0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d            = cnt_inc;
                    busy_d           = 1'b1;
                    reg_write_d      = 1'b1;
                    reg_write_addr_d = cnt_inc;
                    if (cnt_inc != 5'd31) begin
                        mem_addr_d = ctx_word(base_q, {1'b0, cnt_inc} + 6'd1);
                    end
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q          <= S_IDLE;
            cnt_q            <= '0;
            base_q           <= '0;
            reg_read_addr_q  <= '0;
            reg_write_addr_q <= '0;
            reg_write_q      <= 1'b0;
            mem_addr_q       <= '0;
            mem_write_q      <= 1'b0;
            busy_q           <= 1'b0;
            done_q           <= 1'b0;
        end else begin
            state_q          <= state_d;
            cnt_q            <= cnt_d;
            base_q           <= base_d;
            reg_read_addr_q  <= reg_read_addr_d;
            reg_write_addr_q <= reg_write_addr_d;
            reg_write_q      <= reg_write_d;
            mem_addr_q       <= mem_addr_d;
            mem_write_q      <= mem_write_d;
            busy_q           <= busy_d;
            done_q           <= done_d;
        end
    end

    assign regReadAddr  = reg_read_addr_q;
    assign regWriteAddr = reg_write_addr_q;
    assign regWrite     = reg_write_q;
    assign memAddr      = mem_addr_q;
    assign memWrite     = mem_write_q;
    assign busy         = busy_q;
    assign done         = done_q;

    // Data paths are pass-through, gated so nothing leaks while idle or in reset.
    assign memWriteData = mem_write_q ? regReadData : '0;
    assign regWriteData = reg_write_q ? memReadData : '0;

endmodule

// File: tb/tb_context_switch_engine.sv
// Randomized scoreboard bench for context_switch_engine: memory/bank models,
// a queue of expected strobes and done pulses, and a negedge monitor.
module tb_context_switch_engine;

    localparam int CTX_BASE  = 0;
    localparam int CTX_WORDS = 32;
    localparam int AW        = 10;
    localparam int MEMSZ     = 1 << AW;
    localparam logic [31:0] SENT = 32'h5EED_0000;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          mode;
    logic [3:0]    idx;
    logic [4:0]    reg_read_addr;
    logic [31:0]   reg_read_data;
    logic [4:0]    reg_write_addr;
    logic [31:0]   reg_write_data;
    logic          reg_write;
    logic [AW-1:0] mem_addr;
    logic          mem_write;
    logic [31:0]   mem_write_data;
    logic [31:0]   mem_rdata;
    logic          busy;
    logic          done;

    logic [31:0] mem  [MEMSZ];
    logic [31:0] bank [32];
    logic [31:0] saved [32];

    int total = 0;
    int bad   = 0;
    int cyc = 0, busy_run = 0, last_strobe_cyc = 0, last_done_cyc = 0, busy_gap = 0;
    int memw_count = 0, done_count = 0;
    logic busy_prev = 1'b0;

    typedef struct {
        int          kind;   // 0 = memory write, 1 = register write, 2 = done
        int          addr;
        logic [31:0] data;   // for done: expected busy length
    } exp_t;
    exp_t sb_q[$];

    context_switch_engine #(
        .CTX_BASE  (CTX_BASE),
        .CTX_WORDS (CTX_WORDS),
        .ADDR_WIDTH(AW)
    ) dut (
        .clock         (clk),
        .reset         (rst),
        .start         (start),
        .mode          (mode),
        .indiceProcesso(idx),
        .regReadAddr   (reg_read_addr),
        .regReadData   (reg_read_data),
        .regWriteAddr  (reg_write_addr),
        .regWriteData  (reg_write_data),
        .regWrite      (reg_write),
        .memAddr       (mem_addr),
        .memWrite      (mem_write),
        .memWriteData  (mem_write_data),
        .memReadData   (mem_rdata),
        .busy          (busy),
        .done          (done)
    );

    always #5 clk = ~clk;

    assign reg_read_data = bank[reg_read_addr];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic int ctx_addr(input int p, input int i);
        return (CTX_BASE + p * CTX_WORDS + i) % MEMSZ;
    endfunction

    task automatic push_expected(input logic m, input int p);
        exp_t e;
        for (int i = 1; i < 32; i++) begin
            e.kind = m ? 1 : 0;
            e.addr = m ? i : ctx_addr(p, i);
            e.data = m ? mem[ctx_addr(p, i)] : bank[i];
            sb_q.push_back(e);
        end
        e.kind = 2;
        e.addr = 0;
        e.data = m ? 32'd32 : 32'd31;
        sb_q.push_back(e);
    endtask

    task automatic issue(input logic m, input int p);
        push_expected(m, p);
        @(posedge clk); #1;
        start = 1'b1;
        mode  = m;
        idx   = 4'(p);
        @(posedge clk); #1;
        start = 1'b0;
        mode  = 1'($urandom);
        idx   = 4'($urandom);
    endtask

    task automatic wait_done(input string name);
        bit seen = 1'b0;
        for (int n = 0; n < 80; n++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        check({name, "_done_seen"}, 64'(seen), 64'(1));
    endtask

    // Synchronous data memory and register bank write port.
    task automatic models();
        logic          m_we, r_we;
        logic [AW-1:0] m_a;
        logic [4:0]    r_a;
        logic [31:0]   m_d, r_d;
        forever begin
            @(posedge clk);
            m_we = mem_write;
            m_a  = mem_addr;
            m_d  = mem_write_data;
            r_we = reg_write;
            r_a  = reg_write_addr;
            r_d  = reg_write_data;
            if (m_we) mem[m_a] = m_d;
            if (r_we) bank[r_a] = r_d;
            mem_rdata = mem[m_a];
        end
    endtask

    task automatic monitor();
        exp_t e;
        int   k;
        forever begin
            @(negedge clk);
            if (rst) begin
                busy_run  = 0;
                busy_prev = 1'b0;
                continue;
            end
            cyc++;
            if (busy && !busy_prev) busy_gap = cyc - last_done_cyc;
            busy_prev = busy;
            if (busy) begin
                busy_run++;
                check("strobe_exclusive", 64'(mem_write & reg_write), 64'(0));
            end
            if (mem_write || reg_write || done) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_event", 64'({mem_write, reg_write, done}), 64'(0));
                end else begin
                    e = sb_q.pop_front();
                    k = mem_write ? 0 : (reg_write ? 1 : 2);
                    check("event_kind", 64'(k), 64'(e.kind));
                    if (k == e.kind) begin
                        case (k)
                            0: begin
                                check("mem_addr", 64'(mem_addr), 64'(e.addr));
                                check("mem_data", 64'(mem_write_data), 64'(e.data));
                            end
                            1: begin
                                check("reg_addr", 64'(reg_write_addr), 64'(e.addr));
                                check("reg_data", 64'(reg_write_data), 64'(e.data));
                            end
                            default: begin
                                check("busy_length", 64'(busy_run), 64'(e.data));
                                check("busy_in_done", 64'(busy), 64'(0));
                                check("done_latency", 64'(cyc - last_strobe_cyc), 64'(1));
                            end
                        endcase
                    end
                end
            end
            if (mem_write || reg_write) last_strobe_cyc = cyc;
            if (mem_write) memw_count++;
            if (done) begin
                done_count++;
                busy_run      = 0;
                last_done_cyc = cyc;
            end
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int m0, c0, dc, p, base;
        logic m;
        rst   = 1'b1;
        start = 1'b0;
        mode  = 1'b0;
        idx   = 4'd0;
        for (int i = 0; i < MEMSZ; i++) mem[i] = SENT ^ 32'(i);
        for (int i = 0; i < 32; i++) bank[i] = 32'd0;
        fork
            models();
            monitor();
        join_none

        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs",
              64'({busy, done, reg_write, mem_write, mem_addr, reg_read_addr,
                   reg_write_addr, reg_write_data}), 64'(0));
        rst = 1'b0;

        // Directed save of process 3.
        for (int i = 1; i < 32; i++) bank[i] = 32'(100 + i);
        issue(1'b0, 3);
        wait_done("save3");
        check("save3_addr96_untouched", 64'(mem[96]), 64'(SENT ^ 32'd96));
        check("save3_addr127", 64'(mem[127]), 64'(131));

        // Directed restore of process 2.
        for (int i = 0; i < 32; i++) mem[64 + i] = 32'hA000 + 32'(i);
        for (int i = 1; i < 32; i++) bank[i] = 32'd0;
        m0 = memw_count;
        issue(1'b1, 2);
        wait_done("restore2");
        check("restore2_r0", 64'(bank[0]), 64'(0));
        check("restore2_r31", 64'(bank[31]), 64'(32'hA01F));
        check("restore2_no_memwrite", 64'(memw_count - m0), 64'(0));

        // Round trip through process 5.
        for (int i = 1; i < 32; i++) begin
            bank[i]  = $urandom;
            saved[i] = bank[i];
        end
        issue(1'b0, 5);
        wait_done("rt_save5");
        for (int i = 1; i < 32; i++) bank[i] = 32'hFFFF_FFFF;
        issue(1'b1, 5);
        wait_done("rt_restore5");
        for (int i = 1; i < 32; i++) check("roundtrip_reg", 64'(bank[i]), 64'(saved[i]));

        // Start pulses mid-SAVE and in DONE are ignored; the next IDLE start is taken.
        for (int i = 1; i < 32; i++) bank[i] = $urandom;
        m0 = memw_count;
        issue(1'b0, 7);
        repeat (5) @(posedge clk);
        #1;
        start = 1'b1;
        mode  = 1'b1;
        idx   = 4'd9;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done("save7");
        check("save7_write_count", 64'(memw_count - m0), 64'(31));
        push_expected(1'b0, 8);
        start = 1'b1;
        mode  = 1'b0;
        idx   = 4'd8;
        @(posedge clk);
        @(posedge clk); #1;
        start = 1'b0;
        wait_done("save8");
        check("restart_gap", 64'(busy_gap), 64'(2));

        // Randomized transfers; the first hits the top process.
        for (int t = 0; t < 8; t++) begin
            p = (t == 0) ? 15 : int'($urandom_range(0, 15));
            m = (t == 0) ? 1'b0 : 1'($urandom_range(0, 1));
            if (!m) begin
                for (int i = 1; i < 32; i++) bank[i] = $urandom;
            end else begin
                for (int i = 0; i < 32; i++) mem[ctx_addr(p, i)] = $urandom;
            end
            issue(m, p);
            wait_done("random");
            if (t == 0) check("idx15_addr511", 64'(mem[511]), 64'(bank[31]));
        end

        // Reset during a save after ten committed writes.
        p    = int'($urandom_range(0, 15));
        base = ctx_addr(p, 0);
        for (int i = 0; i < 32; i++) mem[ctx_addr(p, i)] = SENT ^ 32'(i);
        for (int i = 1; i < 32; i++) bank[i] = $urandom;
        c0 = memw_count;
        dc = done_count;
        issue(1'b0, p);
        for (int n = 0; n < 60; n++) begin
            @(negedge clk); #1;
            if (memw_count - c0 >= 10) break;
        end
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        check("midreset_outputs",
              64'({busy, done, reg_write, mem_write, mem_addr, reg_read_addr,
                   reg_write_addr, reg_write_data}), 64'(0));
        sb_q.delete();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("midreset_no_done", 64'(done_count), 64'(dc));
        check("midreset_write_count", 64'(memw_count - c0), 64'(10));
        for (int i = 1; i < 32; i++) begin
            if (i <= 10) check("midreset_committed", 64'(mem[ctx_addr(p, i)]), 64'(bank[i]));
            else         check("midreset_unwritten", 64'(mem[ctx_addr(p, i)]), 64'(SENT ^ 32'(i)));
        end
        check("midreset_base_untouched", 64'(mem[base]), 64'(SENT));
        check("scoreboard_drained", 64'(sb_q.size()), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
